regfile_debug_port: RTL and testbench
=====================================

Name: regfile_debug_port

Overview:
- Debug-side initiator for the 64-bit integer register file's read/write port.
- Accepts single-register read, single-register write and full-dump commands from the debug/test interface.
- Sequences the register file address, write-enable and data lines, and returns results over a valid/ready response channel.
- The core is halted externally while this block is busy; the block does no arbitration with the core's own ports.

Parameters:
- DATA_WIDTH, 64, register width.
- ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, registers walked by a dump; must be ≤ 2^ADDR_WIDTH.

Ports:
- in_Clk  input  1  clock, rising edge.
- in_Rst  input  1  synchronous reset, active-high.
- in_cmd_valid  input  1  command present.
- out_cmd_ready  output  1  block can accept a command.
- in_cmd_op  input  2  command: 00 read, 01 write, 10 dump, 11 reserved.
- in_cmd_addr  input  ADDR_WIDTH  register index for read/write.
- in_cmd_data  input  DATA_WIDTH  write data.
- out_rsp_valid  output  1  response present.
- in_rsp_ready  input  1  consumer accepts response.
- out_rsp_data  output  DATA_WIDTH  read data; 0 for write ack and error.
- out_rsp_addr  output  ADDR_WIDTH  register index this response refers to.
- out_rsp_last  output  1  final response of a command.
- out_rsp_err  output  1  reserved op.
- out_rf_addr  output  ADDR_WIDTH  register file read address.
- in_rf_data  input  DATA_WIDTH  register file read data; combinational, same cycle.
- out_rf_writeAddr  output  ADDR_WIDTH  register file write address.
- out_rf_data  output  DATA_WIDTH  register file write data.
- out_rf_write_En  output  1  register file write enable.
- out_busy  output  1  state != IDLE.

Behaviour:
- Reset behaviour:
  - All flops are cleared on in_Clk rising edge while in_Rst=1.
  - State goes to IDLE and the dump counter goes to 0.
  - While in_Rst=1, every output is 0, including out_cmd_ready, which is gated by !in_Rst.
  - Reset mid-command abandons the command: no further write_En and no response.
- States: IDLE, RD, WR, RESP.
- Command accept:
  - out_cmd_ready = (state==IDLE) && !in_Rst.
  - Accept on the edge where in_cmd_valid && out_cmd_ready.
  - On accept, op, addr and data are latched; in_cmd_* are ignored afterwards.
- IDLE transitions:
  - read → RD, latched index = in_cmd_addr.
  - write → WR.
  - dump → RD, index = 0.
  - reserved → RESP with err=1, data=0, last=1.
- RD (1 cycle):
  - out_rf_addr = latched index.
  - in_rf_data is captured into the response register at the end of the cycle.
  - → RESP; last=1 for read, last=(index==NUM_REGS-1) for dump.
- WR (1 cycle):
  - out_rf_writeAddr and out_rf_data are driven from the latched values.
  - out_rf_write_En=1, except when the index is 0: enable stays 0 and the ack is still returned.
  - → RESP with data=0, last=1, err=0.
- RESP:
  - out_rsp_valid=1; data, addr, last and err are held stable until the in_rsp_ready handshake.
  - On handshake, if dump and not last: index+1 → RD. Otherwise → IDLE.
- out_rf_write_En is 0 in every state except WR.
- out_rf_addr is 0 outside RD.
- Latency:
  - Read or write accepted at edge N: RD/WR occupies cycle N+1; rsp_valid is high from cycle N+2.
  - Dump with in_rsp_ready held at 1: 32 responses, one every 2 cycles; out_busy is high for 64 cycles.
- Backpressure:
  - in_rsp_ready=0 stalls in RESP indefinitely with no change to outputs.
  - No commands are accepted while busy.
- Index arithmetic: the dump counter is ADDR_WIDTH wide and never wraps, because it stops at NUM_REGS-1.

Test Plan:
- Reset held 3 cycles with in_cmd_valid=1 → all outputs 0; after release, out_cmd_ready=1, out_busy=0, no response.
- Write op=01, addr=5, data=0xDEADBEEF_00000001 accepted at edge N → out_rf_write_En=1 with writeAddr=5 and that data for exactly cycle N+1; ack response addr=5, data=0, last=1 at N+2; write to addr=0 → write_En stays 0, ack still returned.
- Read addr=5 with the bench model returning 0xDEADBEEF_00000001 → out_rf_addr=5 in cycle N+1; response data=0xDEADBEEF_00000001, addr=5, last=1, err=0 at N+2.
- Dump, registers preloaded with i*0x11, in_rsp_ready=1 → 32 responses, addr 0..31, data i*0x11, last only on addr 31; IDLE after 64 busy cycles.
- Dump with in_rsp_ready toggled randomly, plus in_cmd_valid held high throughout → no responses lost or duplicated, outputs stable while stalled, no second command accepted until IDLE.
- Reserved op=11 → one response with err=1, data=0, last=1, no write_En; in_Rst pulsed during a dump at addr 10 → outputs 0 next cycle, no further responses.

Source files
------------

// File: rtl/regfile_debug_port.sv
// Debug-side initiator for the integer register file: single read, single write and full dump
// commands, with results returned over a valid/ready response channel.
module regfile_debug_port #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst,
    input  logic                  in_cmd_valid,
    output logic                  out_cmd_ready,
    input  logic [1:0]            in_cmd_op,
    input  logic [ADDR_WIDTH-1:0] in_cmd_addr,
    input  logic [DATA_WIDTH-1:0] in_cmd_data,
    output logic                  out_rsp_valid,
    input  logic                  in_rsp_ready,
    output logic [DATA_WIDTH-1:0] out_rsp_data,
    output logic [ADDR_WIDTH-1:0] out_rsp_addr,
    output logic                  out_rsp_last,
    output logic                  out_rsp_err,
    output logic [ADDR_WIDTH-1:0] out_rf_addr,
    input  logic [DATA_WIDTH-1:0] in_rf_data,
    output logic [ADDR_WIDTH-1:0] out_rf_writeAddr,
    output logic [DATA_WIDTH-1:0] out_rf_data,
    output logic                  out_rf_write_En,
    output logic                  out_busy
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [1:0]              r_op;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_last;
    logic                    r_rsp_err;
    logic                    w_accept;
    logic                    w_handshake;
    logic                    w_dump_more;

    assign w_accept    = (r_state == StIdle) && in_cmd_valid;
    assign w_handshake = (r_state == StResp) && in_rsp_ready;
    assign w_dump_more = (r_op == OP_DUMP) && !r_rsp_last;

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (in_cmd_valid) begin
                    case (in_cmd_op)
                        OP_READ:  w_state_next = StRd;
                        OP_WRITE: w_state_next = StWr;
                        OP_DUMP:  w_state_next = StRd;
                        default:  w_state_next = StResp;
                    endcase
                end
            end
            StRd:   w_state_next = StResp;
            StWr:   w_state_next = StResp;
            StResp: begin
                if (in_rsp_ready) begin
                    w_state_next = w_dump_more ? StRd : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Latched command and response registers; held stable while the response is stalled.
    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            r_op       <= 2'b00;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_rsp_last <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= in_cmd_op;
                r_idx      <= (in_cmd_op == OP_DUMP) ? '0 : in_cmd_addr;
                r_wdata    <= in_cmd_data;
                r_rsp_data <= '0;
                r_rsp_last <= 1'b1;
                r_rsp_err  <= (in_cmd_op == 2'b11);
            end
            if (r_state == StRd) begin
                r_rsp_data <= in_rf_data;
                r_rsp_last <= (r_op == OP_READ) || (r_idx == LAST_IDX);
                r_rsp_err  <= 1'b0;
            end
            if (r_state == StWr) begin
                r_rsp_data <= '0;
                r_rsp_last <= 1'b1;
                r_rsp_err  <= 1'b0;
            end
            if (w_handshake && w_dump_more) begin
                r_idx <= r_idx + ONE_IDX;
            end
        end
    end

    // Every output is forced low while reset is asserted, whatever state the flops hold.
    always_comb begin
        out_cmd_ready    = 1'b0;
        out_rsp_valid    = 1'b0;
        out_rsp_data     = '0;
        out_rsp_addr     = '0;
        out_rsp_last     = 1'b0;
        out_rsp_err      = 1'b0;
        out_rf_addr      = '0;
        out_rf_writeAddr = '0;
        out_rf_data      = '0;
        out_rf_write_En  = 1'b0;
        out_busy         = 1'b0;
        if (!in_Rst) begin
            out_cmd_ready = (r_state == StIdle);
            out_busy      = (r_state != StIdle);
            unique case (r_state)
                StRd: out_rf_addr = r_idx;
                StWr: begin
                    out_rf_writeAddr = r_idx;
                    out_rf_data      = r_wdata;
                    out_rf_write_En  = (r_idx != '0);
                end
                StResp: begin
                    out_rsp_valid = 1'b1;
                    out_rsp_data  = r_rsp_data;
                    out_rsp_addr  = r_idx;
                    out_rsp_last  = r_rsp_last;
                    out_rsp_err   = r_rsp_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_debug_port.sv
// Directed testbench for regfile_debug_port with a combinational register file model.
module tb_regfile_debug_port;

    logic        in_Clk = 1'b0;
    logic        in_Rst = 1'b1;
    logic        in_cmd_valid = 1'b0;
    logic        out_cmd_ready;
    logic [1:0]  in_cmd_op = 2'b00;
    logic [4:0]  in_cmd_addr = '0;
    logic [63:0] in_cmd_data = '0;
    logic        out_rsp_valid;
    logic        in_rsp_ready = 1'b1;
    logic [63:0] out_rsp_data;
    logic [4:0]  out_rsp_addr;
    logic        out_rsp_last;
    logic        out_rsp_err;
    logic [4:0]  out_rf_addr;
    logic [63:0] in_rf_data;
    logic [4:0]  out_rf_writeAddr;
    logic [63:0] out_rf_data;
    logic        out_rf_write_En;
    logic        out_busy;

    logic [63:0] rf [32];
    logic [148:0] all_out;
    int errors = 0;
    int checks = 0;

    localparam logic [63:0] WDATA = 64'hDEADBEEF_00000001;

    always #5 in_Clk = ~in_Clk;

    assign in_rf_data = rf[out_rf_addr];
    assign all_out = {out_cmd_ready, out_rsp_valid, out_rsp_data, out_rsp_addr, out_rsp_last,
                      out_rsp_err, out_rf_addr, out_rf_writeAddr, out_rf_data, out_rf_write_En,
                      out_busy};

    regfile_debug_port #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .NUM_REGS  (32)
    ) dut (
        .in_Clk          (in_Clk),
        .in_Rst          (in_Rst),
        .in_cmd_valid    (in_cmd_valid),
        .out_cmd_ready   (out_cmd_ready),
        .in_cmd_op       (in_cmd_op),
        .in_cmd_addr     (in_cmd_addr),
        .in_cmd_data     (in_cmd_data),
        .out_rsp_valid   (out_rsp_valid),
        .in_rsp_ready    (in_rsp_ready),
        .out_rsp_data    (out_rsp_data),
        .out_rsp_addr    (out_rsp_addr),
        .out_rsp_last    (out_rsp_last),
        .out_rsp_err     (out_rsp_err),
        .out_rf_addr     (out_rf_addr),
        .in_rf_data      (in_rf_data),
        .out_rf_writeAddr(out_rf_writeAddr),
        .out_rf_data     (out_rf_data),
        .out_rf_write_En (out_rf_write_En),
        .out_busy        (out_busy)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge in_Clk);
        #1;
    endtask

    task automatic test_reset();
        in_Rst = 1'b1;
        in_cmd_valid = 1'b1;
        in_cmd_op = 2'b01;
        in_cmd_addr = 5'd5;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h want 0", i, all_out);
            end
        end
        in_Rst = 1'b0;
        in_cmd_valid = 1'b0;
        #1;
        checks++;
        if ({out_cmd_ready, out_busy, out_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: ready/busy/rsp_valid=%b want 100",
                     {out_cmd_ready, out_busy, out_rsp_valid});
        end
        tick();
        checks++;
        if ({out_cmd_ready, out_busy, out_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle: ready/busy/rsp_valid=%b want 100",
                     {out_cmd_ready, out_busy, out_rsp_valid});
        end
    endtask

    task automatic test_write(input logic [4:0] addr, input logic [63:0] data);
        logic exp_en;
        exp_en = (addr != 5'd0);
        in_rsp_ready = 1'b1;
        in_cmd_valid = 1'b1;
        in_cmd_op = 2'b01;
        in_cmd_addr = addr;
        in_cmd_data = data;
        tick();
        in_cmd_valid = 1'b0;
        in_cmd_addr = 5'd31;
        in_cmd_data = '1;
        checks++;
        if ({out_rf_write_En, out_rf_writeAddr, out_rf_data, out_rsp_valid, out_busy}
            !== {exp_en, (exp_en ? addr : addr), data, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL write_cycle addr %0d: en=%b waddr=%0d wdata=%h rsp_valid=%b busy=%b want en=%b waddr=%0d wdata=%h",
                     addr, out_rf_write_En, out_rf_writeAddr, out_rf_data, out_rsp_valid,
                     out_busy, exp_en, addr, data);
        end
        tick();
        checks++;
        if ({out_rf_write_En, out_rsp_valid, out_rsp_addr, out_rsp_data, out_rsp_last,
             out_rsp_err} !== {1'b0, 1'b1, addr, 64'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL write_ack addr %0d: en=%b valid=%b addr=%0d data=%h last=%b err=%b",
                     addr, out_rf_write_En, out_rsp_valid, out_rsp_addr, out_rsp_data,
                     out_rsp_last, out_rsp_err);
        end
        tick();
        checks++;
        if ({out_busy, out_rsp_valid, out_cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL write_idle: busy/valid/ready=%b want 001",
                     {out_busy, out_rsp_valid, out_cmd_ready});
        end
    endtask

    task automatic test_read();
        rf[5] = WDATA;
        in_rsp_ready = 1'b1;
        in_cmd_valid = 1'b1;
        in_cmd_op = 2'b00;
        in_cmd_addr = 5'd5;
        tick();
        in_cmd_valid = 1'b0;
        in_cmd_addr = 5'd9;
        checks++;
        if ({out_rf_addr, out_rf_write_En, out_rsp_valid} !== {5'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_rd: rf_addr=%0d en=%b valid=%b want 5 0 0",
                     out_rf_addr, out_rf_write_En, out_rsp_valid);
        end
        tick();
        checks++;
        if ({out_rsp_valid, out_rsp_data, out_rsp_addr, out_rsp_last, out_rsp_err, out_rf_addr}
            !== {1'b1, WDATA, 5'd5, 1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL read_rsp: valid=%b data=%h addr=%0d last=%b err=%b rf_addr=%0d want data %h",
                     out_rsp_valid, out_rsp_data, out_rsp_addr, out_rsp_last, out_rsp_err,
                     out_rf_addr, WDATA);
        end
        tick();
    endtask

    task automatic test_dump();
        int k;
        int busy_cnt;
        int cyc;
        for (int i = 0; i < 32; i++) rf[i] = 64'(i) * 64'h11;
        k = 0;
        busy_cnt = 0;
        in_rsp_ready = 1'b1;
        in_cmd_valid = 1'b1;
        in_cmd_op = 2'b10;
        in_cmd_addr = 5'd7;
        tick();
        in_cmd_valid = 1'b0;
        cyc = 0;
        while (out_busy && cyc < 200) begin
            busy_cnt++;
            if (out_rsp_valid) begin
                checks++;
                if ({out_rsp_addr, out_rsp_data, out_rsp_last}
                    !== {5'(k), 64'(k) * 64'h11, (k == 31)}) begin
                    errors++;
                    $display("FAIL dump_rsp %0d: addr=%0d data=%h last=%b", k, out_rsp_addr,
                             out_rsp_data, out_rsp_last);
                end
                k++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (k !== 32 || busy_cnt !== 64) begin
            errors++;
            $display("FAIL dump_count: responses=%0d busy_cycles=%0d want 32 64", k, busy_cnt);
        end
    endtask

    task automatic test_dump_backpressure();
        int k;
        int cyc;
        logic stalled;
        logic [69:0] held;
        k = 0;
        stalled = 1'b0;
        held = '0;
        for (int i = 0; i < 32; i++) rf[i] = 64'(i) * 64'h11;
        in_rsp_ready = 1'b0;
        in_cmd_valid = 1'b1;
        in_cmd_op = 2'b10;
        tick();
        cyc = 0;
        while (out_busy && cyc < 2000) begin
            in_cmd_addr = 5'($urandom);
            if (out_cmd_ready) begin
                errors++;
                $display("FAIL bp_ready_while_busy: cmd_ready=1 at cycle %0d", cyc);
            end
            if (out_rsp_valid) begin
                checks++;
                if (stalled && {out_rsp_data, out_rsp_addr, out_rsp_last} !== held) begin
                    errors++;
                    $display("FAIL bp_stable: got %h want %h",
                             {out_rsp_data, out_rsp_addr, out_rsp_last}, held);
                end
                if ({out_rsp_addr, out_rsp_data, out_rsp_last, out_rsp_err}
                    !== {5'(k), 64'(k) * 64'h11, (k == 31), 1'b0}) begin
                    errors++;
                    $display("FAIL bp_rsp %0d: addr=%0d data=%h last=%b err=%b", k,
                             out_rsp_addr, out_rsp_data, out_rsp_last, out_rsp_err);
                end
                held = {out_rsp_data, out_rsp_addr, out_rsp_last};
                in_rsp_ready = 1'($urandom);
                if (in_rsp_ready) begin
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        in_cmd_valid = 1'b0;
        in_rsp_ready = 1'b1;
        checks++;
        if (k !== 32 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: responses=%0d busy=%b want 32 0", k, out_busy);
        end
        tick();
        checks++;
        if (out_busy !== 1'b0 || out_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_second_cmd: busy=%b valid=%b want 0 0", out_busy,
                     out_rsp_valid);
        end
    endtask

    task automatic test_reserved();
        in_rsp_ready = 1'b0;
        in_cmd_valid = 1'b1;
        in_cmd_op = 2'b11;
        in_cmd_addr = 5'd3;
        tick();
        in_cmd_valid = 1'b0;
        checks++;
        if ({out_rsp_valid, out_rsp_err, out_rsp_data, out_rsp_last, out_rf_write_En}
            !== {1'b1, 1'b1, 64'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reserved_rsp: valid=%b err=%b data=%h last=%b en=%b",
                     out_rsp_valid, out_rsp_err, out_rsp_data, out_rsp_last, out_rf_write_En);
        end
        in_rsp_ready = 1'b1;
        tick();
        checks++;
        if ({out_busy, out_rsp_valid, out_rf_write_En} !== 3'b000) begin
            errors++;
            $display("FAIL reserved_done: busy/valid/en=%b want 000",
                     {out_busy, out_rsp_valid, out_rf_write_En});
        end
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        int extra;
        in_rsp_ready = 1'b1;
        in_cmd_valid = 1'b1;
        in_cmd_op = 2'b10;
        tick();
        in_cmd_valid = 1'b0;
        cyc = 0;
        while (!(out_rsp_valid && out_rsp_addr == 5'd10) && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 100) begin
            errors++;
            $display("FAIL midrst_reach10: addr 10 not seen, last addr=%0d", out_rsp_addr);
        end
        in_Rst = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 0", all_out);
        end
        tick();
        in_Rst = 1'b0;
        #1;
        checks++;
        if ({out_busy, out_rsp_valid, out_cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_idle: busy/valid/ready=%b want 001",
                     {out_busy, out_rsp_valid, out_cmd_ready});
        end
        extra = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (out_rsp_valid || out_rf_write_En || out_busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d active cycles after reset want 0", extra);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_write(5'd5, WDATA);
        test_write(5'd0, 64'h0123_4567_89AB_CDEF);
        test_read();
        test_dump();
        test_dump_backpressure();
        test_reserved();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
